// File: rtl/i2c_poll_seq_pkg.sv
// Shared definitions for the I2C poll sequencer: register map, SCR bits, FSM states, SET word builder.
// Optional macro I2C_POLL_SEQ_CFG_WR_EN adds the CFGWR/WAITC states.
package i2c_pkg;

    localparam logic [31:0] SCR_OFS = 32'h0000_0000;
    localparam logic [31:0] SET_OFS = 32'h0000_0004;

    localparam int ACK_B   = 0;
    localparam int START_B = 1;
    localparam int BUSY_B  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT1  = 3'd2,
        ST_FETCH  = 3'd3,
        ST_DRAIN  = 3'd4
`ifdef I2C_POLL_SEQ_CFG_WR_EN
        , ST_CFGWR = 3'd5,
        ST_WAITC  = 3'd6
`endif
    } state_t;

    // SET word: [6:0] device address, [15:8] register, [23:16] tx byte.
    function automatic logic [31:0] set_word(input logic [6:0] addr,
                                             input logic [7:0] rg,
                                             input logic [7:0] tx);
        return {8'h00, tx, rg, 1'b0, addr};
    endfunction

endpackage

// File: rtl/i2c_poll_seq_if.sv
// Wishbone classic single-transfer bus between the poll sequencer (master) and the I2C register slave.
// Handshake: cyc/stb/we/adr/dat_o are raised together and held until ack_i, then dropped the next cycle.
interface i2c_poll_seq_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/i2c_poll_seq_wbm_single_xfer.sv
// Single Wishbone access engine: launches one access per request and guarantees an idle gap after each ack.
module wbm_single_xfer (
    input  logic                  clk,
    input  logic                  reset,
    i2c_poll_seq_if.master        wb,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [31:0]           i_adr,
    input  logic [31:0]           i_dat,
    output logic                  o_done,
    output logic [31:0]           o_rdata,
    output logic                  o_active
);

    logic        r_cyc;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_dat;

    // A new access can only start from r_cyc=0, so the cycle after an ack is always idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= 32'h0;
            r_dat <= 32'h0;
        end else if (r_cyc) begin
            if (wb.wbm_ack_i) begin
                r_cyc <= 1'b0;
                r_we  <= 1'b0;
            end
        end else if (i_req) begin
            r_cyc <= 1'b1;
            r_we  <= i_we;
            r_adr <= i_adr;
            r_dat <= i_dat;
        end
    end

    assign wb.wbm_cyc_o = r_cyc;
    assign wb.wbm_stb_o = r_cyc;
    assign wb.wbm_we_o  = r_we;
    assign wb.wbm_adr_o = r_adr;
    assign wb.wbm_sel_o = 4'hF;
    assign wb.wbm_dat_o = r_dat;

    assign o_done   = r_cyc & wb.wbm_ack_i;
    assign o_rdata  = wb.wbm_dat_i;
    assign o_active = r_cyc;

endmodule

// File: rtl/i2c_poll_seq.sv
// Periodic/triggered I2C register read sequencer driving the i2c_master_wb slave over Wishbone.
// Optional macro I2C_POLL_SEQ_CFG_WR_EN: write CFG_DATA to CFG_REG before every read.
module i2c_poll_seq
    import i2c_pkg::*;
#(
    parameter int          PERIOD_CYCLES  = 50_000_000,
    parameter logic [6:0]  SLAVE_ADDR     = 7'h63,
    parameter logic [7:0]  DATA_REG       = 8'h00,
    parameter logic [7:0]  CFG_REG        = 8'h01,
    parameter logic [7:0]  CFG_DATA       = 8'h00,
    parameter int          TIMEOUT_CYCLES = 200_000,
    parameter logic [31:0] BASE_ADR       = 32'h0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           trigger,
    i2c_poll_seq_if.master wbm,
    output logic [7:0]     result,
    output logic           result_valid,
    output logic           busy,
    output logic           err_nack,
    output logic           err_timeout,
    output state_t         state_dbg
);

    localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [PW-1:0] P_LAST   = PW'(PERIOD_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]   ADR_SCR  = BASE_ADR + SCR_OFS;
    localparam logic [31:0]   ADR_SET  = BASE_ADR + SET_OFS;
    localparam logic [31:0]   RD_WORD  = set_word(SLAVE_ADDR, DATA_REG, 8'h00);
`ifdef I2C_POLL_SEQ_CFG_WR_EN
    localparam logic [31:0]   CFG_WORD = set_word(SLAVE_ADDR, CFG_REG, CFG_DATA);
`endif

    state_t        r_state;
    logic [PW-1:0] r_pcnt;
    logic [TW-1:0] r_tcnt;
    logic          r_pend;
    logic [7:0]    r_result;
    logic          r_result_valid;
    logic          r_err_nack;
    logic          r_err_timeout;

    logic          w_tick;
    logic          w_req_in;
    logic          w_start;
    logic          w_poll;
    logic          w_to;
    logic          w_req;
    logic          w_we;
    logic [31:0]   w_adr;
    logic [31:0]   w_dat;
    logic          w_done;
    logic          w_active;
    logic [31:0]   w_rdata;
    logic          w_scr_done;
    logic          w_scr_ack;
    logic          w_unused;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                r_pcnt <= '0;
        else if (!enable)          r_pcnt <= '0;
        else if (r_pcnt == P_LAST) r_pcnt <= '0;
        else                       r_pcnt <= r_pcnt + 1'b1;
    end

    assign w_tick   = enable && (r_pcnt == P_LAST);
    assign w_req_in = w_tick || trigger;
    assign w_start  = (r_state == ST_IDLE) && (r_pend || w_req_in);

`ifdef I2C_POLL_SEQ_CFG_WR_EN
    assign w_poll = (r_state == ST_WAIT1) || (r_state == ST_DRAIN) || (r_state == ST_WAITC);
`else
    assign w_poll = (r_state == ST_WAIT1) || (r_state == ST_DRAIN);
`endif
    assign w_to       = w_poll && (r_tcnt == T_LAST);
    assign w_scr_done = w_rdata[START_B] && !w_rdata[BUSY_B];
    assign w_scr_ack  = w_rdata[ACK_B];
    assign w_unused   = ^w_rdata[31:8];

    // The IDLE request is issued in the same cycle the start is decided so the bus moves one cycle later.
    always_comb begin
        w_req = 1'b0;
        w_we  = 1'b0;
        w_adr = ADR_SCR;
        w_dat = 32'h0;
        case (r_state)
            ST_IDLE: begin
                w_req = w_start;
                w_adr = ADR_SET;
`ifdef I2C_POLL_SEQ_CFG_WR_EN
                w_we  = 1'b1;
                w_dat = CFG_WORD;
`else
                w_dat = RD_WORD;
`endif
            end
            ST_LAUNCH, ST_FETCH: begin
                w_req = 1'b1;
                w_adr = ADR_SET;
                w_dat = RD_WORD;
            end
            ST_WAIT1, ST_DRAIN: w_req = !w_to;
`ifdef I2C_POLL_SEQ_CFG_WR_EN
            ST_CFGWR: begin
                w_req = 1'b1;
                w_we  = 1'b1;
                w_adr = ADR_SET;
                w_dat = CFG_WORD;
            end
            ST_WAITC: w_req = !w_to;
`endif
            default: ;
        endcase
    end

    wbm_single_xfer u_xfer (
        .clk      (clk),
        .reset    (reset),
        .wb       (wbm),
        .i_req    (w_req),
        .i_we     (w_we),
        .i_adr    (w_adr),
        .i_dat    (w_dat),
        .o_done   (w_done),
        .o_rdata  (w_rdata),
        .o_active (w_active)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_tcnt         <= '0;
            r_pend         <= 1'b0;
            r_result       <= 8'h00;
            r_result_valid <= 1'b0;
            r_err_nack     <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (w_req_in && (r_state != ST_IDLE)) r_pend <= 1'b1;
            if (w_poll && (r_tcnt != T_LAST))     r_tcnt <= r_tcnt + 1'b1;
            case (r_state)
                ST_IDLE: if (w_start) begin
                    r_pend        <= 1'b0;
                    r_err_nack    <= 1'b0;
                    r_err_timeout <= 1'b0;
`ifdef I2C_POLL_SEQ_CFG_WR_EN
                    r_state       <= ST_CFGWR;
`else
                    r_state       <= ST_LAUNCH;
`endif
                end
`ifdef I2C_POLL_SEQ_CFG_WR_EN
                ST_CFGWR: if (w_done) begin
                    r_state <= ST_WAITC;
                    r_tcnt  <= '0;
                end
                ST_WAITC: begin
                    if (w_to && (w_done || !w_active)) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else if (w_done && w_scr_done) begin
                        if (w_scr_ack) r_state <= ST_LAUNCH;
                        else begin
                            r_err_nack <= 1'b1;
                            r_state    <= ST_IDLE;
                        end
                    end
                end
`endif
                ST_LAUNCH: if (w_done) begin
                    r_state <= ST_WAIT1;
                    r_tcnt  <= '0;
                end
                // On timeout an access in flight is allowed to finish; no new one is requested.
                ST_WAIT1: begin
                    if (w_to && (w_done || !w_active)) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else if (w_done && w_scr_done) begin
                        if (w_scr_ack) r_state <= ST_FETCH;
                        else begin
                            r_err_nack <= 1'b1;
                            r_state    <= ST_IDLE;
                        end
                    end
                end
                ST_FETCH: if (w_done) begin
                    r_result       <= w_rdata[7:0];
                    r_result_valid <= 1'b1;
                    r_state        <= ST_DRAIN;
                    r_tcnt         <= '0;
                end
                ST_DRAIN: begin
                    if (w_to && (w_done || !w_active)) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else if (w_done && w_scr_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign busy         = (r_state != ST_IDLE);
    assign err_nack     = r_err_nack;
    assign err_timeout  = r_err_timeout;
    assign state_dbg    = r_state;

endmodule

// File: tb/tb_i2c_poll_seq.sv
// Directed bench for i2c_poll_seq with a reactive Wishbone slave model and an access-order scoreboard.
module tb_i2c_poll_seq;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       trigger = 1'b0;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;
  logic       err_nack;
  logic       err_timeout;
  state_t     state_dbg;

  i2c_poll_seq_if wb();

  i2c_poll_seq #(
    .PERIOD_CYCLES  (100),
    .SLAVE_ADDR     (7'h63),
    .DATA_REG       (8'h00),
    .CFG_REG        (8'h01),
    .CFG_DATA       (8'h11),
    .TIMEOUT_CYCLES (50),
    .BASE_ADR       (32'h0)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .enable       (enable),
    .trigger      (trigger),
    .wbm          (wb),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .err_nack     (err_nack),
    .err_timeout  (err_timeout),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0]  exp_q[$];
  logic [8:0]  obs_q[$];
  logic [31:0] obs_dat_q[$];

  int         busy_left = 0;
  logic [7:0] scr_final = 8'h03;
  logic [7:0] fetch_data = 8'h00;
  int         set4_n = 0;
  int         cyc_n = 0;
  logic       prev_busy = 1'b0;
  int         rise_q[$];
  int         rv_cnt = 0;

  // Slave: one-cycle ack, SCR reads busy while busy_left>0, first SET read returns a stale byte.
  always @(posedge clk) begin
    if (!rst_n) begin
      wb.wbm_ack_i <= 1'b0;
      wb.wbm_dat_i <= 32'h0;
    end else if (wb.wbm_cyc_o && wb.wbm_stb_o && !wb.wbm_ack_i) begin
      wb.wbm_ack_i <= 1'b1;
      obs_q.push_back({wb.wbm_we_o, wb.wbm_adr_o[7:0]});
      obs_dat_q.push_back(wb.wbm_dat_o);
      if (!wb.wbm_we_o && wb.wbm_adr_o[7:0] == 8'h00) begin
        if (busy_left > 0) begin
          wb.wbm_dat_i <= 32'h0000_0004;
          busy_left = busy_left - 1;
        end else begin
          wb.wbm_dat_i <= {24'h0, scr_final};
        end
      end else if (!wb.wbm_we_o) begin
        wb.wbm_dat_i <= (set4_n == 0) ? 32'h0000_00EE : {24'h0, fetch_data};
        set4_n = set4_n + 1;
      end
    end else begin
      wb.wbm_ack_i <= 1'b0;
    end
  end

  always @(negedge clk) begin
    cyc_n = cyc_n + 1;
    if (busy && !prev_busy) rise_q.push_back(cyc_n);
    prev_busy = busy;
    if (result_valid) rv_cnt = rv_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic prep(input int bl, input logic [7:0] scr, input logic [7:0] fd);
    exp_q.delete();
    obs_q.delete();
    obs_dat_q.delete();
    busy_left = bl;
    scr_final = scr;
    fetch_data = fd;
    set4_n = 0;
    rv_cnt = 0;
  endtask

  task automatic pulse_trigger;
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input int max, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      cycles++;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (wb.wbm_cyc_o !== 1'b0) begin n_err++; $display("FAIL reset_cyc: got %b want 0", wb.wbm_cyc_o); end
    n_cmp++; if (wb.wbm_stb_o !== 1'b0) begin n_err++; $display("FAIL reset_stb: got %b want 0", wb.wbm_stb_o); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL reset_result: got %h want 00", result); end
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_rv: got %b want 0", result_valid); end
    n_cmp++; if ({err_nack, err_timeout} !== 2'b00) begin n_err++; $display("FAIL reset_errs: got %b want 00", {err_nack, err_timeout}); end
    n_cmp++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({wb.wbm_cyc_o, busy} !== 2'b00) begin n_err++; $display("FAIL idle_after_reset: got %b want 00", {wb.wbm_cyc_o, busy}); end
  endtask

  task automatic test_reset_mid;
    bit found;
    prep(1000, 8'h04, 8'h00);
    pulse_trigger();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
`ifdef I2C_POLL_SEQ_CFG_WR_EN
      if (state_dbg == ST_WAITC && wb.wbm_cyc_o) begin found = 1'b1; break; end
`else
      if (state_dbg == ST_WAIT1 && wb.wbm_cyc_o) begin found = 1'b1; break; end
`endif
      @(negedge clk);
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL mid_reach_poll: got %b want 1", found); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (wb.wbm_cyc_o !== 1'b0) begin n_err++; $display("FAIL mid_reset_cyc: got %b want 0", wb.wbm_cyc_o); end
    n_cmp++; if (wb.wbm_stb_o !== 1'b0) begin n_err++; $display("FAIL mid_reset_stb: got %b want 0", wb.wbm_stb_o); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL mid_reset_result: got %h want 00", result); end
    @(negedge clk);
    rst_n = 1'b1;
    busy_left = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_read;
    int cyc;
    bit ok;
    prep(2, 8'h03, 8'h5A);
`ifdef I2C_POLL_SEQ_CFG_WR_EN
    exp_q = '{9'h104, 9'h000, 9'h000, 9'h000, 9'h004, 9'h000, 9'h004, 9'h000};
`else
    exp_q = '{9'h004, 9'h000, 9'h000, 9'h000, 9'h004, 9'h000};
`endif
    pulse_trigger();
    wait_idle(300, cyc, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL read_done: got %b want 1", ok); end
    n_cmp++; if (result !== 8'h5A) begin n_err++; $display("FAIL read_result: got %h want 5a", result); end
    n_cmp++; if (rv_cnt !== 1) begin n_err++; $display("FAIL read_rv_pulses: got %0d want 1", rv_cnt); end
    n_cmp++; if ({err_nack, err_timeout} !== 2'b00) begin n_err++; $display("FAIL read_errs: got %b want 00", {err_nack, err_timeout}); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL read_n_access: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) begin
        n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL read_access_%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
    if (obs_dat_q.size() > 0) begin
`ifdef I2C_POLL_SEQ_CFG_WR_EN
      n_cmp++; if (obs_dat_q[0] !== 32'h0011_0163) begin n_err++; $display("FAIL read_first_dat: got %h want 00110163", obs_dat_q[0]); end
`else
      n_cmp++; if (obs_dat_q[0] !== 32'h0000_0063) begin n_err++; $display("FAIL read_first_dat: got %h want 00000063", obs_dat_q[0]); end
`endif
    end
  endtask

  task automatic test_nack;
    int cyc;
    bit ok;
    prep(0, 8'h02, 8'hC3);
`ifdef I2C_POLL_SEQ_CFG_WR_EN
    exp_q = '{9'h104, 9'h000};
`else
    exp_q = '{9'h004, 9'h000};
`endif
    pulse_trigger();
    wait_idle(300, cyc, ok);
    repeat (5) @(negedge clk);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL nack_done: got %b want 1", ok); end
    n_cmp++; if (err_nack !== 1'b1) begin n_err++; $display("FAIL nack_flag: got %b want 1", err_nack); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL nack_timeout_flag: got %b want 0", err_timeout); end
    n_cmp++; if (rv_cnt !== 0) begin n_err++; $display("FAIL nack_rv_pulses: got %0d want 0", rv_cnt); end
    n_cmp++; if (result !== 8'h5A) begin n_err++; $display("FAIL nack_result_kept: got %h want 5a", result); end
    n_cmp++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL nack_state: got %0d want %0d", state_dbg, ST_IDLE); end
    n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL nack_n_access: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) begin
        n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL nack_access_%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_timeout;
    int cyc;
    bit ok;
    int n_acc;
    prep(100000, 8'h04, 8'h00);
    pulse_trigger();
    wait_idle(200, cyc, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL to_done: got %b want 1", ok); end
    n_cmp++; if (cyc < 50 || cyc > 58) begin n_err++; $display("FAIL to_latency: got %0d want 50..58", cyc); end
    n_cmp++; if (err_timeout !== 1'b1) begin n_err++; $display("FAIL to_flag: got %b want 1", err_timeout); end
    n_cmp++; if (err_nack !== 1'b0) begin n_err++; $display("FAIL to_nack_flag: got %b want 0", err_nack); end
    n_acc = obs_q.size();
    repeat (10) @(negedge clk);
    n_cmp++; if (wb.wbm_cyc_o !== 1'b0) begin n_err++; $display("FAIL to_bus_idle: got %b want 0", wb.wbm_cyc_o); end
    n_cmp++; if (obs_q.size() !== n_acc) begin n_err++; $display("FAIL to_no_more_access: got %0d want %0d", obs_q.size(), n_acc); end
    prep(0, 8'h03, 8'h77);
    pulse_trigger();
    n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL to_cleared_on_start: got %b want 0", err_timeout); end
    wait_idle(300, cyc, ok);
    n_cmp++; if (result !== 8'h77) begin n_err++; $display("FAIL to_recover_result: got %h want 77", result); end
  endtask

  task automatic test_period;
    int cyc;
    bit ok;
    prep(0, 8'h03, 8'h21);
    rise_q.delete();
    @(negedge clk);
    enable = 1'b1;
    repeat (330) @(negedge clk);
    enable = 1'b0;
    wait_idle(100, cyc, ok);
    n_cmp++; if (rise_q.size() !== 3) begin n_err++; $display("FAIL period_n_seq: got %0d want 3", rise_q.size()); end
    if (rise_q.size() >= 3) begin
      n_cmp++; if (rise_q[1] - rise_q[0] !== 100) begin n_err++; $display("FAIL period_gap1: got %0d want 100", rise_q[1] - rise_q[0]); end
      n_cmp++; if (rise_q[2] - rise_q[1] !== 100) begin n_err++; $display("FAIL period_gap2: got %0d want 100", rise_q[2] - rise_q[1]); end
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit ok;
    prep(0, 8'h03, 8'h33);
    rise_q.delete();
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if (rise_q.size() > 0) break;
      @(negedge clk);
    end
    n_cmp++; if (rise_q.size() !== 1) begin n_err++; $display("FAIL b2b_first_seq: got %0d want 1", rise_q.size()); end
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_at_trigger: got %b want 1", busy); end
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (60) @(negedge clk);
    enable = 1'b0;
    wait_idle(100, cyc, ok);
    n_cmp++; if (rise_q.size() !== 2) begin n_err++; $display("FAIL b2b_n_seq: got %0d want 2", rise_q.size()); end
    if (rise_q.size() >= 2) begin
      n_cmp++; if (rise_q[1] - rise_q[0] >= 100) begin n_err++; $display("FAIL b2b_extra_gap: got %0d want <100", rise_q[1] - rise_q[0]); end
    end
  endtask

  task automatic test_tick_trigger;
    int cyc;
    bit ok;
    prep(0, 8'h03, 8'h44);
    rise_q.delete();
    @(negedge clk);
    enable = 1'b1;
    repeat (99) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (60) @(negedge clk);
    enable = 1'b0;
    wait_idle(100, cyc, ok);
    n_cmp++; if (rise_q.size() !== 1) begin n_err++; $display("FAIL tick_trigger_n_seq: got %0d want 1", rise_q.size()); end
    n_cmp++; if (rv_cnt !== 1) begin n_err++; $display("FAIL tick_trigger_rv: got %0d want 1", rv_cnt); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_single_read();
    test_nack();
    test_timeout();
    test_period();
    test_back_to_back();
    test_tick_trigger();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
